// File: rtl/ddp_ctrl.sv
// ddp_ctrl: initiator side of a compute-core start/done handshake.
// An operand FIFO feeds a four-state controller (IDLE -> START -> WAIT -> OUT).
// The controller issues one start pulse per operand pair, holds the operands
// until the core reports done, and presents the captured result downstream.
// Optional feature macro: DDP_CTRL_TIMEOUT_EN. When it is defined, a WAIT
// watchdog aborts the operation after TIMEOUT_CYC cycles without done.
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// A valid source holds its payload until the transfer. in_ready is !full
// only. out_valid stays high with out_c stable until out_ready is seen.
module ddp_ctrl #(
  parameter int OPW         = 4,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_a,
  input  logic [OPW-1:0] in_b,
  output logic           core_start,
  output logic [OPW-1:0] core_a,
  output logic [OPW-1:0] core_b,
  input  logic [OPW:0]   core_c,
  input  logic           core_done,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OPW:0]   out_c,
  output logic           busy,
  output logic           timeout_err,
  output logic [1:0]     dbg_state
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  logic [2*OPW-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full, empty, push, pop;

  logic [1:0]       state_q, state_d;
  logic [OPW-1:0]   core_a_q, core_a_d, core_b_q, core_b_d;
  logic [OPW:0]     out_c_q, out_c_d;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = in_valid && !full;

  // FIFO storage is not reset; count and pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_a, in_b};
  end

  // Occupancy next-state: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and count. Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

`ifdef DDP_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`else
  // TIMEOUT_CYC only matters when the watchdog is built in.
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC > 0);
`endif

  // Controller next-state. core_done counts only in WAIT.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    core_a_d = core_a_q;
    core_b_d = core_b_q;
    out_c_d  = out_c_q;
`ifdef DDP_CTRL_TIMEOUT_EN
    tmo_d    = tmo_q;
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop                  = 1'b1;
          {core_a_d, core_b_d} = mem_q[rd_ptr_q];
          state_d              = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
`ifdef DDP_CTRL_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      ST_WAIT: begin
        if (core_done) begin
          out_c_d = core_c;
          state_d = ST_OUT;
`ifdef DDP_CTRL_TIMEOUT_EN
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          // The last WAIT cycle ended without done: drop the op.
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d   = tmo_q + 1'b1;
`endif
        end
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state, held operands and captured result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      core_a_q <= '0;
      core_b_q <= '0;
      out_c_q  <= '0;
    end else begin
      state_q  <= state_d;
      core_a_q <= core_a_d;
      core_b_q <= core_b_d;
      out_c_q  <= out_c_d;
    end
  end

`ifdef DDP_CTRL_TIMEOUT_EN
  // Watchdog counter and sticky error flag; only rst clears the flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign in_ready   = !full;
  assign core_start = (state_q == ST_START);
  assign core_a     = core_a_q;
  assign core_b     = core_b_q;
  assign out_valid  = (state_q == ST_OUT);
  assign out_c      = out_c_q;
  assign busy       = (state_q != ST_IDLE) || !empty;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ddp_ctrl.sv
// tb_ddp_ctrl: self-checking bench for ddp_ctrl. A behavioural core returns a+b
// after a programmable latency. A scoreboard queues a+b for each accepted pair
// and checks every result leaving the block. Build with +define+DDP_CTRL_TIMEOUT_EN
// to exercise the watchdog.
module tb_ddp_ctrl;
  localparam int OPW = 4;
  localparam int DEPTH = 4;
  localparam int TMO = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [OPW-1:0] in_a = '0, in_b = '0;
  logic           core_start;
  logic [OPW-1:0] core_a, core_b;
  logic [OPW:0]   core_c;
  logic           core_done;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [OPW:0]   out_c;
  logic           busy, timeout_err;
  logic [1:0]     dbg_state;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  logic [OPW:0] exp_q[$];

  ddp_ctrl #(.OPW(OPW), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .core_start(core_start), .core_a(core_a), .core_b(core_b),
    .core_c(core_c), .core_done(core_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
    .busy(busy), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // core model: done arrives core_lat cycles after the start cycle
  int           core_lat = 2;
  bit           core_hang = 1'b0;
  int           cd = 0;
  bit           active = 1'b0;
  logic [OPW-1:0] ha = '0, hb = '0;
  logic         model_done = 1'b0;
  logic [OPW:0] model_c = '0;
  logic         spur_done = 1'b0;

  assign core_done = model_done | spur_done;
  assign core_c    = spur_done ? {(OPW+1){1'b1}} : model_c;

  always @(negedge clk) begin
    model_done = 1'b0;
    if (rst) begin
      active = 1'b0;
      cd = 0;
    end else if (core_start) begin
      active = !core_hang;
      cd = core_lat;
      ha = core_a;
      hb = core_b;
    end else if (active) begin
      checks++;
      if (core_a !== ha || core_b !== hb) begin
        errors++;
        $display("FAIL operand_stable got a=%h b=%h want a=%h b=%h", core_a, core_b, ha, hb);
      end
      cd--;
      if (cd <= 0) begin
        model_done = 1'b1;
        model_c = {1'b0, ha} + {1'b0, hb};
        active = 1'b0;
      end
    end
  end

  // scoreboard: push on input handshake, pop and compare on output handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
      if (out_valid && out_ready) begin
        checks++;
        n_out++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra got out_c=%h want no output", out_c);
        end else begin
          logic [OPW:0] e;
          e = exp_q.pop_front();
          if (out_c !== e) begin
            errors++;
            $display("FAIL sb_data got out_c=%h want %h", out_c, e);
          end
        end
      end
    end
  end

  // out_ready driver: 0 = hold low, 1 = hold high, 2 = random
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // driver tasks (entered and left at posedge+1)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                           input int budget, output bit ok);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || out_valid) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (busy || out_valid) begin
      errors++;
      $display("FAIL idle_%s got busy=%b out_valid=%b want 0 0", tag, busy, out_valid);
    end
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (core_start) found = 1'b1;
      else @(posedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL start_seen got core_start=0 want 1 within 12 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, core_start, busy, timeout_err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got %b want 10000",
               {in_ready, out_valid, core_start, busy, timeout_err});
    end
    checks++;
    if ({core_a, core_b, out_c, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_data got a=%h b=%h c=%h st=%0d want all 0",
               core_a, core_b, out_c, dbg_state);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    ready_mode = 1;
    core_hang = 1'b1;
    for (int i = 0; i < 4; i++) push_pair(4'(i + 1), 4'(i + 2), 10, ok);
    tick();
    tick();
    checks++;
    if (dbg_state !== 2'd2 || busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got st=%0d busy=%b in_ready=%b want 2 1 1", dbg_state, busy, in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, core_start, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL mid_rst got %b want 1000", {in_ready, out_valid, core_start, busy});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    core_hang = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, core_start, busy, dbg_state} !== 6'b100000) begin
      errors++;
      $display("FAIL mid_after got %b want 100000",
               {in_ready, out_valid, core_start, busy, dbg_state});
    end
    tick();
  endtask

  task automatic test_single();
    ready_mode = 1;
    core_lat = 2;
    wait_idle("single_pre");
    in_a = 4'h9;
    in_b = 4'h8;
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (core_start !== (k == 2)) begin
        errors++;
        $display("FAIL single_start cyc%0d got %b want %b", k, core_start, (k == 2));
      end
      checks++;
      if (out_valid !== (k == 5)) begin
        errors++;
        $display("FAIL single_valid cyc%0d got %b want %b", k, out_valid, (k == 5));
      end
      if (k == 5) begin
        checks++;
        if (out_c !== 5'h11) begin
          errors++;
          $display("FAIL single_data got %h want 11", out_c);
        end
      end
      @(posedge clk);
      #1;
      if (k == 0) in_valid = 1'b0;
    end
  endtask

  task automatic test_full();
    bit ok;
    int acc = 0;
    int n0;
    ready_mode = 0;
    core_lat = 2;
    tick();
    n0 = n_out;
    for (int i = 0; i < 6; i++) begin
      push_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 12, ok);
      if (ok) acc++;
    end
    checks++;
    if (acc !== DEPTH + 1) begin
      errors++;
      $display("FAIL full_accepted got %0d want %0d", acc, DEPTH + 1);
    end
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_flags got in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
    end
    ready_mode = 1;
    wait_idle("full");
    checks++;
    if (n_out - n0 !== DEPTH + 1 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL full_drain got outs=%0d left=%0d want %0d 0", n_out - n0, exp_q.size(), DEPTH + 1);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int n0 = n_out;
    ready_mode = 2;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      core_lat = $urandom_range(1, 4);
      repeat ($urandom_range(0, 2)) tick();
      push_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 200, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL wrap_push%0d got not accepted want accepted", i);
      end
    end
    ready_mode = 1;
    wait_idle("wrap");
    checks++;
    if (n_out - n0 !== 3 * DEPTH || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL wrap_count got outs=%0d left=%0d want %0d 0", n_out - n0, exp_q.size(), 3 * DEPTH);
    end
  endtask

  task automatic test_spurious();
    bit ok, found;
    ready_mode = 1;
    core_lat = 3;
    wait_idle("spur_pre");
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || dbg_state !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL spur_idle got ov=%b st=%0d busy=%b want 0 0 0", out_valid, dbg_state, busy);
    end
    @(posedge clk);
    #1;
    push_pair(4'h7, 4'h5, 10, ok);
    wait_start(found);
    spur_done = 1'b1;
    @(posedge clk);
    #1;
    spur_done = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'd2 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL spur_start got st=%0d ov=%b want 2 0", dbg_state, out_valid);
    end
    @(posedge clk);
    #1;
    wait_idle("spur");
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL spur_left got %0d want 0", exp_q.size());
    end
  endtask

`ifdef DDP_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    bit ok, found;
    ready_mode = 1;
    wait_idle("tmo_pre");
    core_hang = 1'b1;
    push_pair(4'h3, 4'h4, 10, ok);
    wait_start(found);
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      checks++;
      if (dbg_state !== 2'd2 || timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL tmo_wait%0d got st=%0d err=%b want 2 0", k, dbg_state, timeout_err);
      end
    end
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'd0 || timeout_err !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL tmo_abort got st=%0d err=%b ov=%b want 0 1 0", dbg_state, timeout_err, out_valid);
    end
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    core_hang = 1'b0;
    core_lat = 2;
    push_pair(4'hA, 4'h6, 10, ok);
    wait_idle("tmo_next");
    checks++;
    if (timeout_err !== 1'b1 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL tmo_sticky got err=%b left=%0d want 1 0", timeout_err, exp_q.size());
    end
  endtask
`else
  task automatic test_no_timeout();
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_tied got %b want 0", timeout_err);
    end
  endtask
`endif

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid();
    test_single();
    test_full();
    test_wrap();
    test_spurious();
`ifdef DDP_CTRL_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
